// File: rtl/evaluate_relax_mc_fp_int.sv
// Multi-channel first-order RC relaxation evaluator.
// Channels share one serial datapath: tau from VREF/VREG, a restoring divide
// for 1/tau, then a saturating update. All channels commit together in DONE.
module evaluate_relax_mc_fp_int #(
   parameter int NCH      = 4,
   parameter int VW       = 14,
   parameter int OW       = 12,
   parameter int CW       = 16,
   parameter int TW       = 16,
   parameter int QW       = 16,
   parameter int A_REF    = 1037,
   parameter int A_REG    = -1248,
   parameter int C_TAU    = 1042,
   parameter int TSHIFT   = 12,
   parameter int DT_SHIFT = 8,
   parameter int TAU_MIN  = 16,
   parameter int O_INIT   = 422
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              step_valid,
   output logic              step_ready,
   input  logic              mode,
   input  logic [NCH*VW-1:0] VREF,
   input  logic [NCH*VW-1:0] VREG,
   input  logic [NCH*OW-1:0] VTGT,
   output logic [NCH*OW-1:0] out,
   output logic              busy,
   output logic              done,
   output logic [NCH-1:0]    clamp_flag
);
   localparam int SW  = VW + CW + 1;
   localparam int PW  = OW + QW + 2;
   localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int BW  = (QW > 1) ? $clog2(QW) : 1;

   localparam logic signed [SW-1:0] AREF_S = SW'(A_REF);
   localparam logic signed [SW-1:0] AREG_S = SW'(A_REG);
   localparam logic signed [SW-1:0] CTAU_S = SW'(C_TAU);
   localparam logic signed [SW-1:0] TMIN_S = SW'(TAU_MIN);
   localparam logic signed [SW-1:0] TMAX_S = SW'((longint'(1) << TW) - 1);
   localparam logic signed [PW-1:0] ZERO_P = '0;
   localparam logic signed [PW-1:0] OMAX_P = PW'((longint'(1) << OW) - 1);

   typedef enum logic [2:0] {S_IDLE, S_TAU, S_DIV, S_UPD, S_DONE} state_e;

   state_e                   state_q, state_d;
   logic [CHW-1:0]           ch_q;
   logic [BW-1:0]            bit_q;
   logic [TW-1:0]            tau_q;
   logic [TW:0]              rem_q;
   logic [QW-1:0]            quo_q;
   logic                     mode_q, done_q;
   logic [NCH-1:0][VW-1:0]   vref_q, vreg_q;
   logic [NCH-1:0][OW-1:0]   vtgt_q, pend_q, out_q;
   logic [NCH-1:0]           pclamp_q, clamp_q;

   // tau for the current channel: affine in VREF/VREG, then clamped
   logic signed [VW-1:0] vref_k, vreg_k;
   logic signed [SW-1:0] s_w, tr_w;
   logic [TW-1:0]        tau_d;
   logic                 clamp_d;
   always_comb begin
      vref_k  = vref_q[ch_q];
      vreg_k  = vreg_q[ch_q];
      s_w     = AREF_S * SW'(vref_k) + AREG_S * SW'(vreg_k);
      tr_w    = (s_w >>> TSHIFT) + CTAU_S;
      tau_d   = TW'(tr_w);
      clamp_d = 1'b0;
      if (tr_w < TMIN_S) begin
         tau_d   = TW'(TAU_MIN);
         clamp_d = 1'b1;
      end else if (tr_w > TMAX_S) begin
         tau_d   = '1;
         clamp_d = 1'b1;
      end
   end

   // one restoring-divide step: shift in a zero, subtract tau if it fits
   logic [TW:0]   rem_sh, rem_d;
   logic [QW-1:0] quo_d;
   logic          ge;
   always_comb begin
      rem_sh = (TW+1)'({rem_q, 1'b0});
      ge     = rem_sh >= {1'b0, tau_q};
      rem_d  = ge ? rem_sh - {1'b0, tau_q} : rem_sh;
      quo_d  = QW'({quo_q, ge});
   end

   // relaxation update: o + floor((tgt - o) * inv / 2^DT_SHIFT), saturated
   logic [OW-1:0]        o_k, tgt_k, upd_d;
   logic signed [PW-1:0] dif_w, prod_w, dlt_w, sum_w;
   always_comb begin
      o_k    = out_q[ch_q];
      tgt_k  = mode_q ? vtgt_q[ch_q] : '0;
      dif_w  = $signed(PW'(tgt_k)) - $signed(PW'(o_k));
      prod_w = dif_w * $signed(PW'(quo_q));
      dlt_w  = prod_w >>> DT_SHIFT;
      sum_w  = $signed(PW'(o_k)) + dlt_w;
      if (sum_w < ZERO_P)      upd_d = '0;
      else if (sum_w > OMAX_P) upd_d = '1;
      else                     upd_d = OW'(sum_w);
   end

   // FSM state register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= S_IDLE;
      else          state_q <= state_d;
   end

   // FSM next state; a step_valid outside IDLE is simply not seen
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (step_valid) state_d = S_TAU;
         S_TAU:  state_d = S_DIV;
         S_DIV:  if (bit_q == BW'(QW - 1)) state_d = S_UPD;
         S_UPD:  state_d = (ch_q == CHW'(NCH - 1)) ? S_DONE : S_TAU;
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // datapath registers: capture, per-channel work, atomic commit in DONE
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ch_q     <= '0;
         bit_q    <= '0;
         tau_q    <= '0;
         rem_q    <= '0;
         quo_q    <= '0;
         mode_q   <= 1'b0;
         done_q   <= 1'b0;
         vref_q   <= '0;
         vreg_q   <= '0;
         vtgt_q   <= '0;
         pend_q   <= '0;
         pclamp_q <= '0;
         clamp_q  <= '0;
         out_q    <= {NCH{OW'(O_INIT)}};
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: if (step_valid) begin
               mode_q <= mode;
               vref_q <= VREF;
               vreg_q <= VREG;
               vtgt_q <= VTGT;
               ch_q   <= '0;
            end
            S_TAU: begin
               tau_q          <= tau_d;
               pclamp_q[ch_q] <= clamp_d;
               rem_q          <= (TW+1)'(1);   // leading 1 of 2^QW
               quo_q          <= '0;
               bit_q          <= '0;
            end
            S_DIV: begin
               rem_q <= rem_d;
               quo_q <= quo_d;
               bit_q <= bit_q + BW'(1);
            end
            S_UPD: begin
               pend_q[ch_q] <= upd_d;
               if (ch_q != CHW'(NCH - 1)) ch_q <= ch_q + CHW'(1);
            end
            S_DONE: begin
               out_q   <= pend_q;
               clamp_q <= pclamp_q;
               done_q  <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign step_ready = (state_q == S_IDLE);
   assign busy       = (state_q != S_IDLE);
   assign done       = done_q;
   assign out        = out_q;
   assign clamp_flag = clamp_q;
endmodule

// File: tb/tb_evaluate_relax_mc_fp_int.sv
// Bench for evaluate_relax_mc_fp_int: directed and random steps checked
// against an arithmetic model of the relaxation rules.
module tb_evaluate_relax_mc_fp_int;
   localparam int NCH = 4;
   localparam int VW  = 14;
   localparam int OW  = 12;

   logic              clk = 1'b0;
   logic              reset_n = 1'b0;
   logic              step_valid = 1'b0;
   logic              mode = 1'b0;
   logic [NCH*VW-1:0] VREF = '0;
   logic [NCH*VW-1:0] VREG = '0;
   logic [NCH*OW-1:0] VTGT = '0;
   logic              step_ready, busy, done;
   logic [NCH*OW-1:0] out;
   logic [NCH-1:0]    clamp_flag;

   evaluate_relax_mc_fp_int dut (
      .clk(clk), .reset_n(reset_n), .step_valid(step_valid), .step_ready(step_ready),
      .mode(mode), .VREF(VREF), .VREG(VREG), .VTGT(VTGT), .out(out),
      .busy(busy), .done(done), .clamp_flag(clamp_flag)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;
   int mo[NCH];
   logic [NCH-1:0] mclamp;
   int r_vref[NCH], r_vreg[NCH], r_vtgt[NCH];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic longint fdiv(input longint a, input longint d);
      if (a >= 0) return a / d;
      return -((-a + d - 1) / d);
   endfunction

   // one integration step of every channel from the committed state
   function automatic void model_step(input int md);
      for (int k = 0; k < NCH; k++) begin
         longint s, tau, inv, tgt, o;
         s   = 64'sd1037 * r_vref[k] - 64'sd1248 * r_vreg[k];
         tau = fdiv(s, 4096) + 1042;
         mclamp[k] = (tau < 16) || (tau > 65535);
         if (tau < 16) tau = 16;
         if (tau > 65535) tau = 65535;
         inv = 65536 / tau;
         tgt = md ? r_vtgt[k] : 0;
         o   = mo[k] + fdiv((tgt - mo[k]) * inv, 256);
         if (o < 0) o = 0;
         if (o > 4095) o = 4095;
         mo[k] = int'(o);
      end
   endfunction

   function automatic logic [NCH*OW-1:0] pack_out();
      logic [NCH*OW-1:0] p;
      for (int k = 0; k < NCH; k++) p[k*OW +: OW] = mo[k][OW-1:0];
      return p;
   endfunction

   task automatic drive_inputs();
      for (int k = 0; k < NCH; k++) begin
         VREF[k*VW +: VW] = r_vref[k][VW-1:0];
         VREG[k*VW +: VW] = r_vreg[k][VW-1:0];
         VTGT[k*OW +: OW] = r_vtgt[k][OW-1:0];
      end
   endtask

   task automatic set_all(input int vr, input int vg, input int vt);
      for (int k = 0; k < NCH; k++) begin
         r_vref[k] = vr; r_vreg[k] = vg; r_vtgt[k] = vt;
      end
   endtask

   task automatic apply_reset();
      reset_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      for (int k = 0; k < NCH; k++) mo[k] = 422;
      mclamp = '0;
   endtask

   // one handshake step; poke disturbs inputs and step_valid while busy
   task automatic run_step(input int md, input bit poke);
      int n;
      bit rdy_bad;
      mode = md[0];
      drive_inputs();
      chk("ready_before_accept", step_ready, 1);
      step_valid = 1'b1;
      @(posedge clk); #1;
      step_valid = 1'b0;
      model_step(md);
      n = 0;
      rdy_bad = 1'b0;
      while (n < 200) begin
         if (poke && n == 1) begin
            for (int k = 0; k < NCH; k++) r_vref[k] = int'($urandom_range(16383)) - 8192;
            mode = ~mode;
            drive_inputs();
         end
         if (poke && n == 30) step_valid = 1'b1;
         if (poke && n == 31) step_valid = 1'b0;
         @(posedge clk); #1;
         n++;
         if (done) break;
         if (step_ready !== 1'b0 || busy !== 1'b1) rdy_bad = 1'b1;
      end
      chk("latency", n, 73);
      chk("ready_low_while_busy", rdy_bad, 0);
      chk("out", out, pack_out());
      chk("clamp_flag", clamp_flag, mclamp);
      @(posedge clk); #1;
      chk("done_single_cycle", done, 0);
   endtask

   initial begin
      logic [NCH*OW-1:0] prev;
      int n;
      bit saw_done;

      // reset state
      apply_reset();
      chk("rst_out", out, pack_out());
      chk("rst_out_ch0", out[OW-1:0], 422);
      chk("rst_ready", step_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_clamp", clamp_flag, 0);

      // decay toward 0 from 422: 319 then 241
      set_all(0, 0, 0);
      run_step(0, 0);
      chk("decay1_ch0", out[OW-1:0], 319);
      chk("decay1_ch3", out[3*OW +: OW], 319);
      run_step(0, 0);
      chk("decay2_ch2", out[2*OW +: OW], 241);

      // relax toward 1000
      apply_reset();
      set_all(0, 0, 1000);
      run_step(1, 0);
      chk("relax_ch1", out[OW +: OW], 561);

      // channel 1 clamps tau to the minimum and saturates
      apply_reset();
      set_all(0, 0, 1000);
      r_vreg[1] = 8191;
      r_vtgt[1] = 4095;
      run_step(1, 0);
      chk("sat_ch1", out[OW +: OW], 4095);
      chk("sat_ch0", out[OW-1:0], 561);
      chk("sat_clamp", clamp_flag, 4'b0010);

      // input changes and step_valid pulses while busy are ignored
      apply_reset();
      set_all(0, 0, 1000);
      run_step(1, 1);
      chk("poke_ch2", out[2*OW +: OW], 561);

      // held step_valid gives back-to-back accepts
      apply_reset();
      set_all(0, 0, 1000);
      mode = 1'b1;
      drive_inputs();
      step_valid = 1'b1;
      n = 0;
      while (n < 200) begin
         @(posedge clk); #1; n++;
         if (done) break;
      end
      chk("held_first_done", done, 1);
      model_step(1);
      chk("held_out1", out, pack_out());
      n = 0;
      while (n < 200) begin
         @(posedge clk); #1; n++;
         if (done) break;
      end
      chk("held_spacing", n, 74);
      model_step(1);
      chk("held_out2", out, pack_out());
      step_valid = 1'b0;
      @(posedge clk); #1;

      // random steps
      for (int i = 0; i < 8; i++) begin
         for (int k = 0; k < NCH; k++) begin
            r_vref[k] = int'($urandom_range(16383)) - 8192;
            r_vreg[k] = int'($urandom_range(16383)) - 8192;
            r_vtgt[k] = int'($urandom_range(4095));
         end
         run_step(int'($urandom_range(1)), 0);
      end

      // target equal to current state: no movement
      for (int k = 0; k < NCH; k++) begin
         r_vtgt[k] = mo[k];
         r_vref[k] = int'($urandom_range(2000));
         r_vreg[k] = 0;
      end
      prev = out;
      run_step(1, 0);
      chk("target_eq_hold", out, prev);

      // mode 0 decays all the way through 1 to 0 and stays there
      apply_reset();
      set_all(0, 0, 0);
      for (int i = 0; i < 28; i++) run_step(0, 0);
      chk("decay_floor", out, 0);

      // reset in the middle of channel 2's divide aborts the step
      set_all(0, 0, 1000);
      mode = 1'b1;
      drive_inputs();
      step_valid = 1'b1;
      @(posedge clk); #1;
      step_valid = 1'b0;
      saw_done = 1'b0;
      repeat (41) begin
         @(posedge clk); #1;
         if (done) saw_done = 1'b1;
      end
      reset_n = 1'b0;
      #1;
      for (int k = 0; k < NCH; k++) mo[k] = 422;
      chk("abort_async_out", out, pack_out());
      chk("abort_ready", step_ready, 1);
      @(posedge clk); #1;
      reset_n = 1'b1;
      repeat (80) begin
         @(posedge clk); #1;
         if (done) saw_done = 1'b1;
      end
      chk("abort_no_done", saw_done, 0);
      chk("abort_out_kept", out, pack_out());
      chk("abort_clamp", clamp_flag, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
